// File: rtl/gpio_link_pkg.sv
// gpio_link_pkg: shared field positions, kinds and receive FSM states for the board-to-board GPIO link
package gpio_link_pkg;
  localparam int WORD_W = 18;
  localparam int STROBE_BIT = 17;
  localparam int KIND_BIT = 16;
  localparam int HALF_BIT = 15;
  localparam int PARITY_BIT = 14;
  localparam int AUDIO_HALF_W = 12;
  localparam logic KIND_TEXT = 1'b0;
  localparam logic KIND_AUDIO = 1'b1;
  typedef enum logic {RX_IDLE, RX_HAVE_HI} rx_state_t;
  function automatic logic [31:0] sext_sample(input logic [AUDIO_HALF_W-1:0] hi, input logic [AUDIO_HALF_W-1:0] lo);
    return {{(32-2*AUDIO_HALF_W){hi[AUDIO_HALF_W-1]}}, hi, lo};
  endfunction
endpackage

// File: rtl/gpio_bus_sync.sv
// gpio_bus_sync: 2-flop synchronizer plus history register, flags each strobe toggle for one cycle
module gpio_bus_sync
  import gpio_link_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [WORD_W-1:0] bus_in,
  output logic [WORD_W-1:0] word,
  output logic              word_strobe
);
  logic [WORD_W-1:0] sync1, sync2;
  // synchronize the bus, keep the previous word and register the strobe-toggle flag alongside it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      word <= '0;
      word_strobe <= 1'b0;
    end else begin
      sync1 <= bus_in;
      sync2 <= sync1;
      word <= sync2;
      word_strobe <= sync2[STROBE_BIT] ^ word[STROBE_BIT];
    end
  end
endmodule

// File: rtl/gpio_frame_receiver.sv
// gpio_frame_receiver: decodes the toggle-strobed GPIO word stream into text bytes and audio samples; GPIO_RX_PARITY_EN enables even-parity checking
module gpio_frame_receiver
  import gpio_link_pkg::*;
#(
  parameter logic [31:0] LINK_TIMEOUT = 32'd5_000_000,
  parameter int ERR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [WORD_W-1:0] gpio_rx,
  output logic [7:0]        text_rx,
  output logic              text_ready_rx,
  output logic [31:0]       audio_received,
  output logic              audio_ready_rx,
  output logic              rx_valid,
  output logic [31:0]       edge_num,
  output logic [ERR_W-1:0]  err_count
);
  logic [WORD_W-1:0] word;
  logic word_strobe, parity_bad, good, is_text, is_hi, err_hit, wd_expire, unused_bits;
  logic [AUDIO_HALF_W-1:0] hi_half;
  logic [31:0] wd_count;
  rx_state_t state;
  gpio_bus_sync u_sync (
    .clock(clock),
    .resetn(resetn),
    .bus_in(gpio_rx),
    .word(word),
    .word_strobe(word_strobe)
  );
`ifdef GPIO_RX_PARITY_EN
  assign parity_bad = ^word[KIND_BIT:0];
`else
  assign parity_bad = 1'b0;
`endif
  assign unused_bits = ^{word[STROBE_BIT], word[PARITY_BIT:AUDIO_HALF_W]};
  assign is_text = word[KIND_BIT] == KIND_TEXT;
  assign is_hi = word[HALF_BIT];
  assign good = word_strobe & ~parity_bad;
  assign err_hit = word_strobe & (parity_bad | (~is_text & (is_hi == (state == RX_HAVE_HI))));
  assign wd_expire = ~word_strobe & (wd_count != LINK_TIMEOUT) & (wd_count + 32'd1 == LINK_TIMEOUT);
  // decode accepted words: text passes straight through, audio halves pair up via the FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RX_IDLE;
      hi_half <= '0;
      text_rx <= '0;
      text_ready_rx <= 1'b0;
      audio_received <= '0;
      audio_ready_rx <= 1'b0;
    end else begin
      text_ready_rx <= good & is_text;
      audio_ready_rx <= good & ~is_text & ~is_hi & (state == RX_HAVE_HI);
      if (good && is_text) text_rx <= word[7:0];
      if (good && !is_text) begin
        state <= is_hi ? RX_HAVE_HI : RX_IDLE;
        if (is_hi) hi_half <= word[AUDIO_HALF_W-1:0];
        else if (state == RX_HAVE_HI) audio_received <= sext_sample(hi_half, word[AUDIO_HALF_W-1:0]);
      end else if (wd_expire) state <= RX_IDLE;
    end
  end
  // count every accepted word and every framing/parity error, the latter saturating
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      edge_num <= '0;
      err_count <= '0;
    end else begin
      if (word_strobe) edge_num <= edge_num + 32'd1;
      if (err_hit && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
  // link watchdog: any accepted word revives the link, a long silence drops it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_count <= '0;
      rx_valid <= 1'b0;
    end else if (word_strobe) begin
      wd_count <= '0;
      rx_valid <= 1'b1;
    end else begin
      if (wd_count != LINK_TIMEOUT) wd_count <= wd_count + 32'd1;
      if (wd_expire) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gpio_frame_receiver.sv
// tb_gpio_frame_receiver: directed scoreboard bench for gpio_frame_receiver
module tb_gpio_frame_receiver;
  logic clock, resetn;
  logic [17:0] gpio_rx;
  logic [7:0] text_rx;
  logic text_ready_rx, audio_ready_rx, rx_valid;
  logic [31:0] audio_received, edge_num;
  logic [7:0] err_count;
  int checks = 0, failures = 0;
  int exp_edge = 0, exp_err = 0;
  typedef struct {logic is_audio; logic [31:0] data;} exp_t;
  exp_t q[$];

  gpio_frame_receiver #(.LINK_TIMEOUT(32'd100), .ERR_W(8)) dut (
    .clock(clock),
    .resetn(resetn),
    .gpio_rx(gpio_rx),
    .text_rx(text_rx),
    .text_ready_rx(text_ready_rx),
    .audio_received(audio_received),
    .audio_ready_rx(audio_ready_rx),
    .rx_valid(rx_valid),
    .edge_num(edge_num),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mkw(input logic kind, input logic half, input logic [13:0] low);
    return {kind, half, ^{kind, half, low}, low};
  endfunction

  task automatic push(input logic is_audio, input logic [31:0] data);
    exp_t e;
    e.is_audio = is_audio;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic send(input logic [16:0] w, input int gap);
    @(negedge clock);
    gpio_rx = {~gpio_rx[17], w};
    exp_edge++;
    repeat (gap) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (text_ready_rx || audio_ready_rx) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_pulse observed text=%b audio=%b expected none", text_ready_rx, audio_ready_rx);
      end else begin
        e = q.pop_front();
        assert (audio_ready_rx === e.is_audio && text_ready_rx === !e.is_audio &&
                (e.is_audio ? audio_received : {24'h0, text_rx}) === e.data) else begin
          failures++;
          $error("FAIL scoreboard observed audio=%b text=%h sample=%h expected audio=%b data=%h",
                 audio_ready_rx, text_rx, audio_received, e.is_audio, e.data);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    gpio_rx = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_text", {24'h0, text_rx}, 32'h0);
    chk("rst_text_rdy", {31'h0, text_ready_rx}, 32'h0);
    chk("rst_audio", audio_received, 32'h0);
    chk("rst_audio_rdy", {31'h0, audio_ready_rx}, 32'h0);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_edge", edge_num, 32'h0);
    chk("rst_err", {24'h0, err_count}, 32'h0);

    push(1'b0, 32'h48);
    gpio_rx = {1'b1, mkw(1'b0, 1'b0, 14'h48)};
    exp_edge++;
    repeat (3) @(posedge clock);
    #1 chk("lat_n2", {31'h0, text_ready_rx}, 32'h0);
    @(posedge clock);
    #1 chk("lat_n3", {31'h0, text_ready_rx}, 32'h1);
    chk("text_48", {24'h0, text_rx}, 32'h48);
    chk("edge_1", edge_num, 32'h1);
    chk("valid_1", {31'h0, rx_valid}, 32'h1);
    @(posedge clock);
    #1 chk("lat_n4", {31'h0, text_ready_rx}, 32'h0);
    repeat (4) @(negedge clock);

    push(1'b1, 32'hFF80_0001);
    send(mkw(1'b1, 1'b1, 14'h800), 6);
    send(mkw(1'b1, 1'b0, 14'h001), 6);
    chk("neg_err", {24'h0, err_count}, exp_err);

    push(1'b0, 32'h41);
    push(1'b1, 32'h0012_3456);
    send(mkw(1'b1, 1'b1, 14'h123), 8);
    send(mkw(1'b0, 1'b0, 14'h41), 8);
    send(mkw(1'b1, 1'b0, 14'h456), 8);
    chk("interleave_err", {24'h0, err_count}, exp_err);

    push(1'b1, 32'h007F_F000);
    send(mkw(1'b1, 1'b0, 14'h555), 8);
    exp_err++;
    send(mkw(1'b1, 1'b1, 14'hABC), 8);
    send(mkw(1'b1, 1'b1, 14'h7FF), 8);
    exp_err++;
    send(mkw(1'b1, 1'b0, 14'h000), 8);
    chk("orphan_err", {24'h0, err_count}, exp_err);
    chk("edge_10", edge_num, exp_edge);

    @(negedge clock);
    gpio_rx = {~gpio_rx[17], mkw(1'b1, 1'b1, 14'h111)};
    exp_edge++;
    repeat (103) @(posedge clock);
    #1 chk("wd_before", {31'h0, rx_valid}, 32'h1);
    @(posedge clock);
    #1 chk("wd_after", {31'h0, rx_valid}, 32'h0);
    send(mkw(1'b1, 1'b0, 14'h222), 8);
    exp_err++;
    chk("wd_discard_err", {24'h0, err_count}, exp_err);
    chk("wd_revive", {31'h0, rx_valid}, 32'h1);

`ifdef GPIO_RX_PARITY_EN
    send(mkw(1'b0, 1'b0, 14'h55) ^ 17'h04000, 8);
    exp_err++;
    chk("parity_err", {24'h0, err_count}, exp_err);
    push(1'b0, 32'h55);
    send(mkw(1'b0, 1'b0, 14'h55), 8);
`endif
    chk("edge_total", edge_num, exp_edge);

    send(mkw(1'b1, 1'b1, 14'h333), 8);
    @(negedge clock);
    resetn = 1'b0;
    gpio_rx = '0;
    #1 chk("mid_rst_edge", edge_num, 32'h0);
    chk("mid_rst_err", {24'h0, err_count}, 32'h0);
    chk("mid_rst_audio", audio_received, 32'h0);
    chk("mid_rst_text", {24'h0, text_rx}, 32'h0);
    chk("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    send(mkw(1'b1, 1'b0, 14'h444), 8);
    chk("post_rst_err", {24'h0, err_count}, 32'h1);
    chk("post_rst_edge", edge_num, 32'h1);
    chk("post_rst_audio", audio_received, 32'h0);

    repeat (4) @(negedge clock);
    chk("queue_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_frame_receiver.md
# gpio_frame_receiver

- Receive end of the board-to-board GPIO link: decodes the 18-bit toggle-strobed word stream driven by the peer board's transmitter into ASCII characters and 32-bit audio samples.
- Sits between the `gpio_rx` half of the `gpio` bank and the processor text path (`text_rx`/`text_ready_rx`) and the audio mixer (`audio_received`/`audio_ready_rx`).
- Also reports link health (`rx_valid`, word and error counters) for LED/seven-segment debug.

## Interface
Parameters:
- LINK_TIMEOUT, 32'd5_000_000 — cycles without a strobe toggle before `rx_valid` drops (100 ms at 50 MHz).
- ERR_W, 8 — width of the saturating error counter.

Ports:
- clock  in  1  — system clock (50 MHz); all logic on rising edge.
- resetn  in  1  — asynchronous, active-low reset.
- gpio_rx  in  18  — raw bus from peer, asynchronous to `clock`.
- text_rx  out  8  — last received ASCII byte.
- text_ready_rx  out  1  — one-cycle pulse, `text_rx` valid.
- audio_received  out  32  — last assembled sample, sign-extended from 24 bits.
- audio_ready_rx  out  1  — one-cycle pulse, `audio_received` valid.
- rx_valid  out  1  — link alive.
- edge_num  out  32  — accepted-word counter, wraps.
- err_count  out  ERR_W  — framing/parity error counter, saturates at all-ones.

## Operation
- Word format: [17] strobe (toggles once per word); [16] kind (0 text, 1 audio); [15] half (audio only: 1 high, 0 low); [14] parity (see Configuration); [11:0] audio payload; [7:0] ASCII for text.
- Audio sample = 24 bits sent high half first: hi word carries sample[23:12], lo word sample[11:0].
- All 18 bits pass through a 2-flop synchronizer and then a third history register. A word is accepted when synchronized strobe ≠ history strobe; fields are taken from the history stage.
- Each accepted word increments `edge_num`, including words later dropped.
- Text word: `text_rx` ← [7:0]; pulse `text_ready_rx`. Accepted in either FSM state; the state is unchanged.
- FSM states and transitions:
  - IDLE, audio hi: store payload, go to HAVE_HI.
  - IDLE, audio lo: orphan; `err_count`+1; stay in IDLE.
  - HAVE_HI, audio lo: `audio_received` ← sign-extend({hi,lo}); pulse `audio_ready_rx`; go to IDLE.
  - HAVE_HI, audio hi: overwrite stored half; `err_count`+1; stay in HAVE_HI.
  - HAVE_HI, timeout: discard the stored half; go to IDLE; no error.
- Watchdog:
  - Counter clears on every accepted word; `rx_valid` goes to 1.
  - When the counter reaches LINK_TIMEOUT: `rx_valid` goes to 0 and the counter holds.
- Reset values: every output is 0, the FSM is IDLE, and all sync/history flops are 0. A partial sample is discarded on reset. The first strobe 0→1 after reset counts as a word.

## Timing
- The peer holds data bits stable from ≥1 cycle before the strobe toggle until ≥4 cycles after it.
- Minimum word period is 6 cycles. Faster streams are unsupported, and any loss is reported only via parity/framing errors.
- Latency: with the toggle first sampled at edge N, `text_ready_rx`/`audio_ready_rx` rise at edge N+3 and stay high for exactly 1 cycle. Data outputs update on the same edge and hold until the next word.
- Pulses never overlap: at most one word is accepted per cycle.
- `err_count` and `edge_num` update on the same edge as the pulse.
- Timeout and word acceptance in the same cycle: the word wins and the counter clears.

## Configuration
- GPIO_RX_PARITY_EN defined: bit [14] is even parity over {[16:15],[13:0]}. A mismatching word is dropped: no pulse, FSM unchanged, `err_count`+1, `edge_num` still incremented.
- GPIO_RX_PARITY_EN undefined: bit [14] is ignored and no parity logic is built.

## Structure
- Package `gpio_link_pkg`:
  - bit positions STROBE_BIT, KIND_BIT, HALF_BIT, PARITY_BIT;
  - KIND_TEXT/KIND_AUDIO;
  - AUDIO_HALF_W = 12;
  - FSM enum {RX_IDLE, RX_HAVE_HI}.
  - The transmitter side uses the same package.
- Sub-module `gpio_bus_sync`: 18-bit 2-flop synchronizer plus history register. Outputs the history word and a one-cycle `word_strobe`.

## Test plan
- Text word `0x0_0048` with strobe 0→1 → `text_ready_rx` 1-cycle pulse at N+3, `text_rx`=0x48, `edge_num`=1.
- Audio hi 0x800 then lo 0x001, 6 cycles apart → single `audio_ready_rx`, `audio_received`=0xFF80_0001, `err_count`=0.
- Hi 0x123, text 'A', lo 0x456 → text pulse 'A', then audio 0x0012_3456.
- Lo word in IDLE, then hi, hi, lo → `err_count`=2, one audio pulse using the second hi.
- LINK_TIMEOUT=100: one word then idle → `rx_valid` 1 until 100 idle cycles then 0. Pending hi is discarded, so a following lo counts as an error.
- With GPIO_RX_PARITY_EN: bad-parity text word → no pulse, `err_count`+1. Assert `resetn` low mid-sample → all outputs 0, next lo is an orphan.
